// File: rtl/seg7_scan_driver_if.sv
// Pin and display-data bundle between the 7-segment scan driver and its neighbours.
// Latency: none, wires only.
// Backpressure: none; the driver free-runs and samples the data fields once per slot.
interface seg7_scan_driver_if;
  logic [3:0] digit_a;
  logic [3:0] digit_b;
  logic       dp_a;
  logic       dp_b;
  logic       blank;
  logic       seg_si;
  logic       seg_sck;
  logic       seg_rck;
  logic       seg_a_en;
  logic       seg_b_en;
  logic       busy;

  modport master (
    input  digit_a, digit_b, dp_a, dp_b, blank,
    output seg_si, seg_sck, seg_rck, seg_a_en, seg_b_en, busy
  );

  modport slave (
    output digit_a, digit_b, dp_a, dp_b, blank,
    input  seg_si, seg_sck, seg_rck, seg_a_en, seg_b_en, busy
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Two-digit 7-segment scan driver: decode, serialise into an external latching shift register, multiplex enables.
// Latency: a digit slot is DIGIT_CYCLES clocks; pattern is latched 17*SCK_DIV clocks after the slot's LOAD cycle.
// Backpressure: none; inputs are sampled only in the LOAD cycle, later changes wait for that digit's next slot.
module seg7_scan_driver #(
  parameter int SCK_DIV        = 4,
  parameter int DIGIT_CYCLES   = 50000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input logic                clock,
  input logic                reset,
  seg7_scan_driver_if.master bus
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, SHOW} state_t;

  state_t        state_q, state_d;
  logic          run_q, run_d;        // 0 only in the reset state; first edge after release enters LOAD
  logic [CW-1:0] cnt_q, cnt_d;
  logic          digit_q, digit_d;    // 0 = digit A, 1 = digit B
  logic [DW-1:0] div_q, div_d;        // cycles spent in the current sck / rck half-period
  logic [2:0]    bit_q, bit_d;        // index of the bit being shifted, 0 = MSB
  logic [7:0]    shreg_q, shreg_d;    // remaining bits, current bit in [7]
  logic          blank_q, blank_d;
  logic          si_q, si_d;
  logic          sck_q, sck_d;
  logic          rck_q, rck_d;
  logic          a_en_q, a_en_d;
  logic          b_en_q, b_en_d;
  logic          busy_q, busy_d;

  logic [3:0]    cur_val;
  logic          cur_dp;
  logic [7:0]    load_byte;

  // Segment pattern {dp,g,f,e,d,c,b,a}; blanking wins over the digit, polarity applied last.
  function automatic logic [7:0] encode(input logic [3:0] v, input logic dp, input logic blk);
    logic [6:0] seg;
    logic [7:0] pat;
    case (v)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    pat = blk ? 8'h00 : {dp, seg};
    if (SEG_ACTIVE_LOW != 0) pat = ~pat;
    return pat;
  endfunction

  assign cur_val   = digit_q ? bus.digit_b : bus.digit_a;
  assign cur_dp    = digit_q ? bus.dp_b : bus.dp_a;
  assign load_byte = encode(cur_val, cur_dp, bus.blank);

  // Next-state and next-output logic; outputs are registered so the pins never glitch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    blank_d = blank_q;
    si_d    = si_q;
    sck_d   = sck_q;
    rck_d   = rck_q;
    a_en_d  = a_en_q;
    b_en_d  = b_en_q;
    busy_d  = busy_q;

    if (!run_q) begin
      // Leaving reset: enter the first LOAD cycle of digit A.
      run_d   = 1'b1;
      state_d = LOAD;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      case (state_q)
        LOAD: begin
          shreg_d = load_byte;
          blank_d = bus.blank;
          si_d    = load_byte[7];
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!sck_q) begin
              sck_d = 1'b1;
            end else begin
              // Falling sck: data may only move now, while sck is low.
              sck_d = 1'b0;
              if (bit_q == 3'd7) begin
                si_d    = 1'b0;
                rck_d   = 1'b1;
                state_d = LATCH;
              end else begin
                bit_d   = bit_q + 3'd1;
                shreg_d = {shreg_q[6:0], 1'b0};
                si_d    = shreg_q[6];
              end
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        LATCH: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            rck_d   = 1'b0;
            busy_d  = 1'b0;
            a_en_d  = !blank_q && !digit_q;
            b_en_d  = !blank_q && digit_q;
            state_d = SHOW;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        SHOW: begin
          // Enable drops on the same edge LOAD begins: break-before-make.
          if (cnt_q == CNT_LAST) begin
            a_en_d  = 1'b0;
            b_en_d  = 1'b0;
            busy_d  = 1'b1;
            digit_d = ~digit_q;
            state_d = LOAD;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= LOAD;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      digit_q <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      blank_q <= 1'b0;
      si_q    <= 1'b0;
      sck_q   <= 1'b0;
      rck_q   <= 1'b0;
      a_en_q  <= 1'b0;
      b_en_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      blank_q <= blank_d;
      si_q    <= si_d;
      sck_q   <= sck_d;
      rck_q   <= rck_d;
      a_en_q  <= a_en_d;
      b_en_q  <= b_en_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.seg_si   = si_q;
  assign bus.seg_sck  = sck_q;
  assign bus.seg_rck  = rck_q;
  assign bus.seg_a_en = a_en_q;
  assign bus.seg_b_en = b_en_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (normal and inverted polarity) driven in lockstep.
// Expected slot contents are queued at each LOAD and checked cycle by cycle by a monitor.
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int DC = 100;

  typedef struct {
    logic [7:0] bval;
    bit         digb;
    bit         blk;
  } exp_t;

  logic clock;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   slot_pos = -2;
  int   slot_num = 0;
  exp_t exp_q[$];

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver_if bus ();
  seg7_scan_driver_if bus2 ();

  assign bus2.digit_a = bus.digit_a;
  assign bus2.digit_b = bus.digit_b;
  assign bus2.dp_a    = bus.dp_a;
  assign bus2.dp_b    = bus.dp_b;
  assign bus2.blank   = bus.blank;

  seg7_scan_driver #(.SCK_DIV(SD), .DIGIT_CYCLES(DC), .SEG_ACTIVE_LOW(0)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  seg7_scan_driver #(.SCK_DIV(SD), .DIGIT_CYCLES(DC), .SEG_ACTIVE_LOW(1)) dut_inv (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Position within the slot as the reference timeline: -1 while in reset, then 0..DC-1.
  always @(posedge clock) begin
    if (!reset) begin
      slot_pos <= -1;
      slot_num <= 0;
    end else begin
      slot_pos <= (slot_pos == DC - 1) ? 0 : slot_pos + 1;
      if (slot_pos == DC - 1) slot_num <= slot_num + 1;
    end
  end

  function automatic logic [7:0] ref_byte(input logic [3:0] v, input logic dp, input logic blk);
    return blk ? 8'h00 : {dp, seg_tbl[v]};
  endfunction

  // Expected {si, sck, rck, a_en, b_en, busy} at slot position p.
  function automatic logic [5:0] exp_pins(input int p, input logic [7:0] b, input bit digb, input bit blk);
    logic si, sck, rck, show;
    si  = 1'b0;
    sck = 1'b0;
    if (p >= 1 && p <= 16 * SD) begin
      sck = ((p - 1) % (2 * SD)) >= SD;
      si  = b[7 - (p - 1) / (2 * SD)];
    end
    rck  = (p >= 16 * SD + 1) && (p <= 17 * SD);
    show = (p >= 17 * SD + 1) && !blk;
    return {si, sck, rck, show && !digb, show && digb, p <= 17 * SD};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s slot %0d pos %0d: got %02h expected %02h", name, slot_num, slot_pos, act, exp);
    end
  endtask

  // Monitor: pops the expected slot at LOAD and checks every cycle of the slot.
  exp_t       cur;
  bit         have_cur = 0;
  logic [7:0] cap, cap2;
  int         ncap;
  logic       prev_sck;

  always @(negedge clock) begin
    if (slot_pos == -1) begin
      check("reset_pins", {2'b00, bus.seg_si, bus.seg_sck, bus.seg_rck, bus.seg_a_en, bus.seg_b_en, bus.busy}, 8'h00);
      check("reset_pins_inv", {2'b00, bus2.seg_si, bus2.seg_sck, bus2.seg_rck, bus2.seg_a_en, bus2.seg_b_en, bus2.busy}, 8'h00);
      have_cur = 0;
    end else if (slot_pos >= 0) begin
      if (slot_pos == 0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL scoreboard_empty slot %0d: got no expected entry, required one", slot_num);
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
        end
        cap = 8'h00;
        cap2 = 8'h00;
        ncap = 0;
        prev_sck = 1'b0;
      end
      if (have_cur) begin
        check("pins", {2'b00, bus.seg_si, bus.seg_sck, bus.seg_rck, bus.seg_a_en, bus.seg_b_en, bus.busy},
              {2'b00, exp_pins(slot_pos, cur.bval, cur.digb, cur.blk)});
        check("pins_inv", {2'b00, bus2.seg_si, bus2.seg_sck, bus2.seg_rck, bus2.seg_a_en, bus2.seg_b_en, bus2.busy},
              {2'b00, exp_pins(slot_pos, ~cur.bval, cur.digb, cur.blk)});
        if (bus.seg_sck && !prev_sck) begin
          cap  = {cap[6:0], bus.seg_si};
          cap2 = {cap2[6:0], bus2.seg_si};
          ncap++;
        end
        prev_sck = bus.seg_sck;
        if (slot_pos == DC - 1) begin
          check("shifted_byte", cap, cur.bval);
          check("shifted_byte_inv", cap2, ~cur.bval);
          check("sck_rising_edges", 8'(ncap), 8'd8);
        end
      end
    end
  end

  task automatic wait_pos(input int target);
    for (int i = 0; i < 3 * DC; i++) begin
      @(posedge clock);
      #1;
      if (slot_pos == target) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL slot_timeout: position %0d not reached, at %0d", target, slot_pos);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  endtask

  task automatic scramble();
    bus.digit_a = 4'($urandom_range(0, 15));
    bus.digit_b = 4'($urandom_range(0, 15));
    bus.dp_a    = 1'($urandom_range(0, 1));
    bus.dp_b    = 1'($urandom_range(0, 1));
    bus.blank   = 1'($urandom_range(0, 1));
  endtask

  // One slot: optionally drive inputs during LOAD, queue the expected byte, disturb inputs mid-shift.
  // mid_mode: 0 none, 1 scramble everything, 2 digit_a <= 7. rst_pos > 0 resets the DUT at that position.
  task automatic do_slot(input bit drive, input logic [3:0] va, input logic [3:0] vb,
                         input logic pa, input logic pb, input logic bk,
                         input int mid_mode, input int rst_pos);
    exp_t e;
    wait_pos(0);
    if (drive) begin
      bus.digit_a = va;
      bus.digit_b = vb;
      bus.dp_a    = pa;
      bus.dp_b    = pb;
      bus.blank   = bk;
    end
    e.digb = slot_num[0];
    e.blk  = bus.blank;
    e.bval = ref_byte(e.digb ? bus.digit_b : bus.digit_a, e.digb ? bus.dp_b : bus.dp_a, bus.blank);
    exp_q.push_back(e);
    if (rst_pos > 0) begin
      wait_pos(rst_pos);
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      reset = 1'b1;
      return;
    end
    wait_pos(3 * SD);
    if (mid_mode == 1) scramble();
    else if (mid_mode == 2) bus.digit_a = 4'h7;
    wait_pos(DC - 1);
  endtask

  task automatic random_slot(input int rst_pos);
    do_slot(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, 1, rst_pos);
  endtask

  initial begin
    reset       = 1'b0;
    bus.digit_a = 4'h0;
    bus.digit_b = 4'h0;
    bus.dp_a    = 1'b0;
    bus.dp_b    = 1'b0;
    bus.blank   = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;

    do_slot(1'b1, 4'h5, 4'hF, 1'b0, 1'b1, 1'b0, 0, 0);   // A: 6D
    do_slot(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);   // B: F1
    do_slot(1'b1, 4'h5, 4'hF, 1'b0, 1'b1, 1'b1, 0, 0);   // A blanked
    do_slot(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);   // B blanked
    do_slot(1'b1, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 2, 0);   // A: 06, digit_a becomes 7 mid-shift
    do_slot(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);   // B: F1
    do_slot(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 0);   // A: 07
    do_slot(1'b1, 4'h8, 4'h8, 1'b0, 1'b0, 1'b0, 0, 0);   // B: 7F, inverted 80
    for (int i = 0; i < 24; i++) random_slot(0);
    random_slot(1 + 6 * SD + 1);                          // A slot, reset during the 4th bit
    do_slot(1'b1, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0, 0, 0);   // A after reset: DB
    for (int i = 0; i < 3; i++) random_slot(0);

    @(negedge clock);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
